// File: rtl/difftest_delayed_update_arbiter.sv
// Round-robin merge of delayed integer writeback reports into one ordered,
// sequence-stamped event stream for the ArchIntDelayedUpdate difftest probe.
module difftest_delayed_update_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_SRC-1:0]           req_valid,
   output logic [NUM_SRC-1:0]           req_ready,
   input  logic [5*NUM_SRC-1:0]         req_address,
   input  logic [64*NUM_SRC-1:0]        req_data,
   input  logic [NUM_SRC-1:0]           req_nack,
   input  logic [7:0]                   coreid,
   input  logic                         out_stall,
   output logic                         out_enable,
   output logic                         out_valid,
   output logic [4:0]                   out_address,
   output logic [63:0]                  out_data,
   output logic                         out_nack,
   output logic [7:0]                   out_coreid,
   output logic [7:0]                   out_index,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]  rr_ptr_r;
   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;
   logic [7:0]     seq_r;
   logic [4:0]     mem_addr_r [DEPTH];
   logic [63:0]    mem_data_r [DEPTH];
   logic           mem_nack_r [DEPTH];

   logic               hit_s;
   logic [NUM_SRC-1:0] pick_s;
   logic [PW-1:0]      pick_idx_s;
   logic [NUM_SRC-1:0] grant_s;
   logic               space_s;
   logic               xfer_s;
   logic               push_s;
   logic               pop_s;
   logic               valid_s;
   logic               enable_s;
   logic [4:0]         sel_addr_s;
   logic [63:0]        sel_data_s;
   logic               sel_nack_s;
   logic [PW-1:0]      rr_next_s;

   // Head-of-queue status; the probe is never fired while reset is held.
   always_comb begin
      valid_s  = (count_r != {CW{1'b0}});
      enable_s = valid_s & ~out_stall & ~reset;
      pop_s    = enable_s;
      space_s  = (count_r < CW'(DEPTH)) | pop_s;
   end

   // Round-robin scan: first requester at or after rr_ptr_r, modulo NUM_SRC.
   always_comb begin
      hit_s      = 1'b0;
      pick_s     = {NUM_SRC{1'b0}};
      pick_idx_s = {PW{1'b0}};
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            if (!hit_s && (j == ((int'(rr_ptr_r) + k) % NUM_SRC)) && req_valid[j]) begin
               hit_s      = 1'b1;
               pick_s[j]  = 1'b1;
               pick_idx_s = PW'(j);
            end else begin
               hit_s = hit_s;
            end
         end
      end
   end

   // Grant only when the winner can be stored this cycle.
   always_comb begin
      if (!reset && hit_s && space_s) begin
         grant_s = pick_s;
      end else begin
         grant_s = {NUM_SRC{1'b0}};
      end
      xfer_s    = |(grant_s & req_valid);
      rr_next_s = PW'((int'(pick_idx_s) + 1) % NUM_SRC);
   end

   // Payload mux of the winning source.
   always_comb begin
      sel_addr_s = 5'd0;
      sel_data_s = 64'd0;
      sel_nack_s = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (pick_s[j]) begin
            sel_addr_s = req_address[5*j +: 5];
            sel_data_s = req_data[64*j +: 64];
            sel_nack_s = req_nack[j];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
      // Writes to x0 are architecturally invisible, so they are dropped here.
      push_s = xfer_s & (sel_addr_s != 5'd0);
   end

   // Control state: pointers, occupancy, arbitration pointer, sequence index.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         seq_r    <= 8'd0;
      end else begin
         if (xfer_s) begin
            rr_ptr_r <= rr_next_s;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
            seq_r    <= seq_r + 8'd1;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (push_s && !reset) begin
         mem_addr_r[wr_ptr_r] <= sel_addr_s;
         mem_data_r[wr_ptr_r] <= sel_data_s;
         mem_nack_r[wr_ptr_r] <= sel_nack_s;
      end
   end

   assign req_ready   = grant_s;
   assign out_valid   = valid_s;
   assign out_enable  = enable_s;
   assign out_address = valid_s ? mem_addr_r[rd_ptr_r] : 5'd0;
   assign out_data    = valid_s ? mem_data_r[rd_ptr_r] : 64'd0;
   assign out_nack    = valid_s ? mem_nack_r[rd_ptr_r] : 1'b0;
   assign out_coreid  = coreid;
   assign out_index   = seq_r;
   assign count       = count_r;

endmodule

// File: tb/tb_difftest_delayed_update_arbiter.sv
// Randomized bench for difftest_delayed_update_arbiter against a queue-based
// model of the arbitration, filtering and FIFO ordering rules.
module tb_difftest_delayed_update_arbiter;
   localparam int N  = 2;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);
   localparam int VW = N + 1 + 1 + 5 + 64 + 1 + 8 + CW + 8;

   logic             clock = 1'b0;
   logic             reset;
   logic [N-1:0]     req_valid, req_ready, req_nack;
   logic [5*N-1:0]   req_address;
   logic [64*N-1:0]  req_data;
   logic [7:0]       coreid;
   logic             out_stall;
   logic             out_enable, out_valid, out_nack;
   logic [4:0]       out_address;
   logic [63:0]      out_data;
   logic [7:0]       out_coreid, out_index;
   logic [CW-1:0]    count;

   difftest_delayed_update_arbiter #(.NUM_SRC(N), .DEPTH(D)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_address(req_address), .req_data(req_data), .req_nack(req_nack),
      .coreid(coreid), .out_stall(out_stall), .out_enable(out_enable),
      .out_valid(out_valid), .out_address(out_address), .out_data(out_data),
      .out_nack(out_nack), .out_coreid(out_coreid), .out_index(out_index),
      .count(count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  a;
      logic [63:0] d;
      logic        n;
   } ev_t;

   ev_t          q[$];
   int           rr, seq;
   logic         pv [N];
   ev_t          pe [N];
   logic [N-1:0] e_ready;
   logic         e_enable;
   int           e_g;
   int           tests, fails;

   function automatic ev_t rand_ev(input logic allow_zero);
      ev_t e;
      e.a = (allow_zero && $urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      e.d = {$urandom, $urandom};
      e.n = 1'($urandom_range(1));
      return e;
   endfunction

   function automatic void drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = pv[i];
         req_address[5*i +: 5] = pe[i].a;
         req_data[64*i +: 64]  = pe[i].d;
         req_nack[i]           = pe[i].n;
      end
   endfunction

   // Model: first pending source from rr, accepted if a slot is or becomes free.
   function automatic void predict();
      e_enable = (q.size() != 0) && !out_stall && !reset;
      e_ready  = '0;
      e_g      = -1;
      if (!reset && (q.size() < D || e_enable)) begin
         for (int k = 0; k < N; k++) begin
            if (e_g < 0 && pv[(rr + k) % N]) e_g = (rr + k) % N;
         end
      end
      if (e_g >= 0) e_ready[e_g] = 1'b1;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      ev_t h;
      h = (q.size() != 0) ? q[0] : '0;
      return {e_ready, q.size() != 0, e_enable, h.a, h.d, h.n, 8'(seq), CW'(q.size()), coreid};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {req_ready, out_valid, out_enable, out_address, out_data, out_nack,
              out_index, count, out_coreid};
   endfunction

   task automatic settle();
      drive();
      #3;
      predict();
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) begin
         q.delete();
         rr  = 0;
         seq = 0;
      end else begin
         if (e_enable) begin
            void'(q.pop_front());
            seq = (seq + 1) % 256;
         end
         if (e_g >= 0) begin
            if (pe[e_g].a != 5'd0) q.push_back(pe[e_g]);
            pv[e_g] = 1'b0;
            rr = (e_g + 1) % N;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; out_stall = 1'b0; coreid = 8'h3C;
      for (int i = 0; i < N; i++) begin pv[i] = 1'b1; pe[i] = rand_ev(1'b0); end
      settle(); tick();
      settle();
      tests++;
      if (obs_vec() !== exp_vec()) begin
         fails++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < N; i++) pv[i] = 1'b0;
      settle();
      tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_index !== 8'd0 || req_ready !== 2'b00) begin
         fails++; $display("FAIL reset_idle got count=%0d valid=%b idx=%0d ready=%b exp 0",
                           count, out_valid, out_index, req_ready);
      end
   endtask

   task automatic test_single();
      pv[0] = 1'b1; pe[0] = '{a: 5'd5, d: 64'hDEAD_BEEF, n: 1'b0};
      settle();
      tests++;
      if (req_ready !== 2'b01 || obs_vec() !== exp_vec()) begin
         fails++; $display("FAIL single_grant got=%h exp=%h", obs_vec(), exp_vec());
      end
      tick(); settle();
      tests++;
      if (out_enable !== 1'b1 || out_address !== 5'd5 || out_data !== 64'hDEAD_BEEF ||
          out_index !== 8'd0 || out_nack !== 1'b0 || out_coreid !== 8'h3C) begin
         fails++; $display("FAIL single_out got en=%b a=%0d d=%h idx=%0d exp en=1 a=5 d=deadbeef idx=0",
                           out_enable, out_address, out_data, out_index);
      end
      tick(); settle();
      tests++;
      if (count !== 3'd0 || obs_vec() !== exp_vec()) begin
         fails++; $display("FAIL single_drained got count=%0d exp 0", count);
      end
      tick();
   endtask

   task automatic test_alternate();
      logic [N-1:0] alt;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!pv[i]) begin pv[i] = 1'b1; pe[i] = rand_ev(1'b0); end
         settle();
         alt = (c % 2 == 0) ? 2'b10 : 2'b01;
         tests++;
         if (req_ready !== alt || obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL alternate_grant c=%0d got=%b exp=%b", c, req_ready, alt);
         end
         if (c > 0) begin
            tests++;
            if (out_enable !== 1'b1 || out_index !== 8'(c)) begin
               fails++; $display("FAIL alternate_index c=%0d got en=%b idx=%0d exp en=1 idx=%0d",
                                 c, out_enable, out_index, c);
            end
         end
         tick();
      end
   endtask

   task automatic test_stall_full();
      out_stall = 1'b1;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!pv[i]) begin pv[i] = 1'b1; pe[i] = rand_ev(1'b0); end
         settle();
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL stall_fill c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
         end
         tick();
      end
      settle();
      tests++;
      if (count !== 3'd4 || req_ready !== 2'b00 || out_enable !== 1'b0) begin
         fails++; $display("FAIL stall_full got count=%0d ready=%b en=%b exp 4 00 0",
                           count, req_ready, out_enable);
      end
      tick();
      out_stall = 1'b0;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < N; i++) if (!pv[i]) begin pv[i] = 1'b1; pe[i] = rand_ev(1'b0); end
         settle();
         tests++;
         if (obs_vec() !== exp_vec() || (c == 0 && (req_ready === 2'b00 || out_enable !== 1'b1))) begin
            fails++; $display("FAIL stall_release c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_reg0_filter();
      int saved;
      for (int c = 0; c < 40 && (q.size() != 0 || pv[0] || pv[1]); c++) begin
         settle(); tick();
      end
      settle();
      tests++;
      if (count !== 3'd0) begin
         fails++; $display("FAIL reg0_drain got count=%0d exp 0", count);
      end
      saved = seq;
      pv[1] = 1'b1; pe[1] = '{a: 5'd0, d: 64'h1234, n: 1'b0};
      settle();
      tests++;
      if (req_ready !== 2'b10) begin
         fails++; $display("FAIL reg0_grant got=%b exp=10", req_ready);
      end
      tick(); settle();
      tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_index !== 8'(saved)) begin
         fails++; $display("FAIL reg0_dropped got count=%0d valid=%b idx=%0d exp 0 0 %0d",
                           count, out_valid, out_index, saved);
      end
      for (int i = 0; i < N; i++) begin pv[i] = 1'b1; pe[i] = rand_ev(1'b0); end
      settle();
      tests++;
      if (req_ready !== 2'b01) begin
         fails++; $display("FAIL reg0_rrptr got=%b exp=01", req_ready);
      end
      tick();
   endtask

   task automatic test_random_wrap();
      int  prev_idx;
      logic saw_wrap;
      int  nack_seen;
      prev_idx = -1; saw_wrap = 1'b0; nack_seen = 0;
      for (int c = 0; c < 420; c++) begin
         for (int i = 0; i < N; i++)
            if (!pv[i] && $urandom_range(3) != 0) begin pv[i] = 1'b1; pe[i] = rand_ev(1'b1); end
         out_stall = ($urandom_range(9) == 0);
         settle();
         tests++;
         if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
         end
         if (out_enable === 1'b1) begin
            if (prev_idx == 255 && out_index === 8'd0) saw_wrap = 1'b1;
            if (out_nack === 1'b1) nack_seen++;
            prev_idx = int'(out_index);
         end
         tick();
      end
      out_stall = 1'b0;
      tests++;
      if (saw_wrap !== 1'b1 || nack_seen == 0) begin
         fails++; $display("FAIL index_wrap got wrap=%b nacks=%0d exp wrap=1 nacks>0", saw_wrap, nack_seen);
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < N; i++) pv[i] = 1'b0;
      for (int c = 0; c < 40 && q.size() != 0; c++) begin settle(); tick(); end
      out_stall = 1'b1;
      for (int c = 0; c < 20 && q.size() < 3; c++) begin
         if (!pv[0]) begin pv[0] = 1'b1; pe[0] = rand_ev(1'b0); end
         settle(); tick();
      end
      pv[0] = 1'b0;
      settle();
      tests++;
      if (count !== 3'd3) begin
         fails++; $display("FAIL midreset_fill got count=%0d exp 3", count);
      end
      reset = 1'b1; out_stall = 1'b0;
      settle();
      tests++;
      if (out_enable !== 1'b0 || req_ready !== 2'b00) begin
         fails++; $display("FAIL midreset_cycle got en=%b ready=%b exp 0 00", out_enable, req_ready);
      end
      tick();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         tests++;
         if (count !== 3'd0 || out_valid !== 1'b0 || out_index !== 8'd0 || out_enable !== 1'b0) begin
            fails++; $display("FAIL midreset_after c=%0d got count=%0d valid=%b idx=%0d en=%b exp all 0",
                              c, count, out_valid, out_index, out_enable);
         end
         tick();
      end
   endtask

   initial begin
      tests = 0; fails = 0; rr = 0; seq = 0;
      for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pe[i] = '0; end
      test_reset();
      test_single();
      test_alternate();
      test_stall_full();
      test_reg0_filter();
      test_random_wrap();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/difftest_delayed_update_arbiter.md
# difftest_delayed_update_arbiter

Merges delayed integer-register writeback reports from several core sources (LSU refill, mul/div unit, and so on) into one ordered stream for the ArchIntDelayedUpdate difftest probe. A round-robin arbiter feeds a small FIFO. The FIFO drains at most one event per cycle into the probe's enable/io_* port set and stamps each event with a wrapping sequence index. The block sits between the core writeback sources and the probe instance, one instance per core.

## Interface
Parameters:
- NUM_SRC, 2: number of requesting sources (2..8).
- DEPTH, 4: FIFO entries (power of two, 2..16).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_SRC  source i has a delayed update pending.
- req_ready  out  NUM_SRC  source i is granted this cycle.
- req_address  in  5*NUM_SRC  destination register; source i occupies bits [5i+4:5i].
- req_data  in  64*NUM_SRC  writeback data; source i occupies bits [64i+63:64i].
- req_nack  in  NUM_SRC  update is a nack, i.e. the writeback was cancelled.
- coreid  in  8  static hart id; copied to every output event.
- out_stall  in  1  the probe cannot take an event this cycle.
- out_enable  out  1  the probe fires this cycle.
- out_valid  out  1  FIFO head holds an event.
- out_address  out  5  head destination register.
- out_data  out  64  head data.
- out_nack  out  1  head nack flag.
- out_coreid  out  8  equal to coreid.
- out_index  out  8  sequence index of the head event.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
Arbitration:
- Each cycle, at most one bit of req_ready is high.
- The grant goes to the first requester with req_valid high, scanning from rr_ptr upward and wrapping modulo NUM_SRC.
- A grant is issued only if space is available: count < DEPTH, or a pop occurs in the same cycle.
- req_ready may depend combinationally on req_valid and out_stall. A source must hold its request stable until it is granted.
- A transfer is req_valid[i] & req_ready[i]. After a transfer, rr_ptr becomes (i+1) mod NUM_SRC. Otherwise rr_ptr holds.

Register-0 filter:
- A granted request with req_address == 0 is consumed and discarded. It is not enqueued and no index is used.
- rr_ptr still advances.
- The filter applies whether or not req_nack is set.

FIFO:
- Entry contents: {address, data, nack}.
- Push on a non-filtered transfer. Pop when out_enable is high.
- Push and pop in the same cycle are permitted at any occupancy, including full, where count is unchanged.
- The FIFO never overflows and never underflows.

Output:
- out_valid = (count != 0).
- out_enable = out_valid & ~out_stall.
- out_address, out_data and out_nack present the head entry whenever out_valid is high. They are 0 when the FIFO is empty.
- out_coreid = coreid.
- out_index = seq. seq increments by 1 on each pop and wraps 255 -> 0.

Reset, sampled at a rising edge with reset high:
- FIFO emptied, so count=0. rr_ptr=0. seq=0.
- out_valid, out_enable, out_address, out_data, out_nack and out_index are all 0. req_ready is all 0 during that cycle.
- A reset asserted mid-stream discards all queued events. Events are not flushed to the probe.
- Requests presented in the reset cycle are not accepted.

## Timing
- Latency: an event accepted in cycle N appears on out_* and may fire in cycle N+1 at the earliest.
- Events fire in the same order they were accepted. Throughput is one event per cycle.
- While the FIFO is full and out_stall=1, all req_ready bits are 0 and the FIFO state is frozen.
- While full with out_stall=0, one grant per cycle continues, because pop and push happen together.
- Fairness: a continuously requesting source waits at most NUM_SRC-1 grants before its own grant, provided space is available.

## Test plan
- Reset, then source 0 sends addr=5, data=0xDEAD_BEEF, nack=0 in cycle 1. Required: out_enable=1 in cycle 2 with out_address=5, out_data=0xDEADBEEF, out_index=0; count returns to 0 in cycle 3.
- Both sources request continuously with out_stall=0. Required: grants alternate 0,1,0,1; out_index runs 0,1,2,3; no source is starved.
- Hold out_stall=1 while both sources request. Required: count reaches 4 and req_ready goes 0. Release the stall: 4 events drain in acceptance order, and new grants resume in the first release cycle because pop and push overlap.
- Source 1 sends addr=0, data=0x1234. Required: req_ready[1]=1, nothing is enqueued, count stays 0, seq is unchanged, and rr_ptr moves to 0.
- Send 256 events with out_stall=0. Required: out_index goes 255 -> 0; nack=1 events propagate with out_nack=1.
- Assert reset with count=3. Required: the next cycle shows count=0, out_valid=0, out_index=0, and no out_enable pulse for the discarded events.
